// File: rtl/eth_tx_arb.sv
// N-channel transmit arbiter: latches one-cycle frame requests, grants one source at a time
// to the frame builder, and holds the grant until tx_done or the watchdog fires.
module eth_tx_arb #(
    parameter int NUM_CH      = 4,
    parameter int OPER_W      = 2,
    parameter int RR_MODE     = 1,
    parameter int TIMEOUT_CYC = 4096,
    localparam int SEL_W      = $clog2(NUM_CH)
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [NUM_CH-1:0]          req_start,
    input  logic [NUM_CH*OPER_W-1:0]   req_oper,
    output logic [NUM_CH-1:0]          req_pending,
    output logic [NUM_CH-1:0]          req_drop,
    input  logic                       tx_done,
    output logic                       tx_start,
    output logic [OPER_W-1:0]          tx_oper,
    output logic [SEL_W-1:0]           tx_sel,
    output logic [NUM_CH-1:0]          grant,
    output logic                       timeout_err
);

    // state   | meaning
    // IDLE    | no transfer; pick a winner when anything is pending
    // GRANT   | winner latched in tx_sel/tx_oper; raise tx_start next
    // WAIT    | transfer in flight; wait for tx_done or watchdog expiry
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

    logic [1:0]               state_q, state_d;
    logic [NUM_CH-1:0]        pending_q, pending_d;
    logic [NUM_CH*OPER_W-1:0] oper_q, oper_d;
    logic [NUM_CH-1:0]        drop_q, drop_d;
    logic                     tx_start_q, tx_start_d;
    logic [OPER_W-1:0]        tx_oper_q, tx_oper_d;
    logic [SEL_W-1:0]         tx_sel_q, tx_sel_d;
    logic [NUM_CH-1:0]        grant_q, grant_d;
    logic                     timeout_q, timeout_d;
    logic [SEL_W-1:0]         ptr_q, ptr_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    logic [SEL_W-1:0]  ptr_eff;
    logic [SEL_W-1:0]  win_hi, win_lo, win;
    logic              any_hi, any_lo;
    logic [OPER_W-1:0] win_oper;
    logic [NUM_CH-1:0] take, sel_onehot;

    // Two descending scans: lowest pending index at/after the pointer, else lowest overall (wrap).
    always_comb begin
        ptr_eff  = (RR_MODE != 0) ? ptr_q : '0;
        win_hi   = '0;
        win_lo   = '0;
        any_hi   = 1'b0;
        any_lo   = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                win_lo = SEL_W'(i);
                any_lo = 1'b1;
                if (SEL_W'(i) >= ptr_eff) begin
                    win_hi = SEL_W'(i);
                    any_hi = 1'b1;
                end
            end
        end
        win      = any_hi ? win_hi : win_lo;
        win_oper = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (SEL_W'(i) == win) win_oper = oper_q[i*OPER_W +: OPER_W];
            sel_onehot[i] = (tx_sel_q == SEL_W'(i));
        end
    end

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        oper_d     = oper_q;
        drop_d     = '0;
        tx_start_d = tx_start_q;
        tx_oper_d  = tx_oper_q;
        tx_sel_d   = tx_sel_q;
        grant_d    = grant_q;
        timeout_d  = 1'b0;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        take       = '0;

        case (state_q)
            S_IDLE: begin
                if (any_lo) begin
                    tx_sel_d  = win;
                    tx_oper_d = win_oper;
                    ptr_d     = (win == SEL_W'(NUM_CH - 1)) ? '0 : win + 1'b1;
                    for (int i = 0; i < NUM_CH; i++) take[i] = (SEL_W'(i) == win);
                    pending_d = pending_q & ~take;
                    state_d   = S_GRANT;
                end
            end
            S_GRANT: begin
                tx_start_d = 1'b1;
                grant_d    = sel_onehot;
                cnt_d      = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (tx_done) begin
                    tx_start_d = 1'b0;
                    grant_d    = '0;
                    state_d    = S_IDLE;
                end else if ((TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST)) begin
                    tx_start_d = 1'b0;
                    grant_d    = '0;
                    timeout_d  = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A new pulse on the channel being granted this cycle re-arms it rather than dropping.
        for (int i = 0; i < NUM_CH; i++) begin
            if (req_start[i]) begin
                if (!pending_q[i] || take[i]) begin
                    pending_d[i]                 = 1'b1;
                    oper_d[i*OPER_W +: OPER_W]   = req_oper[i*OPER_W +: OPER_W];
                end else begin
                    drop_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q    <= S_IDLE;
            pending_q  <= '0;
            oper_q     <= '0;
            drop_q     <= '0;
            tx_start_q <= 1'b0;
            tx_oper_q  <= '0;
            tx_sel_q   <= '0;
            grant_q    <= '0;
            timeout_q  <= 1'b0;
            ptr_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            oper_q     <= oper_d;
            drop_q     <= drop_d;
            tx_start_q <= tx_start_d;
            tx_oper_q  <= tx_oper_d;
            tx_sel_q   <= tx_sel_d;
            grant_q    <= grant_d;
            timeout_q  <= timeout_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign req_pending = pending_q;
    assign req_drop    = drop_q;
    assign tx_start    = tx_start_q;
    assign tx_oper     = tx_oper_q;
    assign tx_sel      = tx_sel_q;
    assign grant       = grant_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_eth_tx_arb.sv
// Bench for eth_tx_arb: instance 0 is round-robin, instance 1 fixed priority, both with a 16-cycle watchdog.
module tb_eth_tx_arb;

    logic       aclk = 1'b0;
    logic       aresetn;
    logic [3:0] req_start_s   [2];
    logic [7:0] req_oper_s    [2];
    logic       tx_done_s     [2];
    logic [3:0] req_pending_s [2];
    logic [3:0] req_drop_s    [2];
    logic       tx_start_s    [2];
    logic [1:0] tx_oper_s     [2];
    logic [1:0] tx_sel_s      [2];
    logic [3:0] grant_s       [2];
    logic       timeout_s     [2];

    int total = 0;
    int bad   = 0;

    always #5 aclk = ~aclk;

    eth_tx_arb #(.NUM_CH(4), .OPER_W(2), .RR_MODE(1), .TIMEOUT_CYC(16)) u_rr (
        .aclk(aclk), .aresetn(aresetn),
        .req_start(req_start_s[0]), .req_oper(req_oper_s[0]),
        .req_pending(req_pending_s[0]), .req_drop(req_drop_s[0]),
        .tx_done(tx_done_s[0]), .tx_start(tx_start_s[0]), .tx_oper(tx_oper_s[0]),
        .tx_sel(tx_sel_s[0]), .grant(grant_s[0]), .timeout_err(timeout_s[0])
    );

    eth_tx_arb #(.NUM_CH(4), .OPER_W(2), .RR_MODE(0), .TIMEOUT_CYC(16)) u_fp (
        .aclk(aclk), .aresetn(aresetn),
        .req_start(req_start_s[1]), .req_oper(req_oper_s[1]),
        .req_pending(req_pending_s[1]), .req_drop(req_drop_s[1]),
        .tx_done(tx_done_s[1]), .tx_start(tx_start_s[1]), .tx_oper(tx_oper_s[1]),
        .tx_sel(tx_sel_s[1]), .grant(grant_s[1]), .timeout_err(timeout_s[1])
    );

    typedef struct {
        logic [3:0] start;
        logic [7:0] oper;
        logic       done;
        logic       exp_start;
        logic [1:0] exp_sel;
        logic [1:0] exp_oper;
        logic [3:0] exp_grant;
        logic [3:0] exp_pend;
        logic [3:0] exp_drop;
    } vec_t;

    vec_t tbl [14];

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse(input int d, input logic [3:0] start, input logic [7:0] oper);
        req_start_s[d] = start;
        req_oper_s[d]  = oper;
        tick();
        req_start_s[d] = 4'b0000;
        req_oper_s[d]  = 8'hFF;
    endtask

    task automatic wait_start(input int d, input string name);
        int n;
        n = 0;
        while (!tx_start_s[d] && n < 40) begin
            tick();
            n++;
        end
        check({name, ".start_seen"}, 32'(tx_start_s[d]), 32'd1);
    endtask

    task automatic serve(input int d, input logic [1:0] sel, input logic [1:0] oper,
                         input int hold, input string name);
        wait_start(d, name);
        check({name, ".sel"},   32'(tx_sel_s[d]),  32'(sel));
        check({name, ".oper"},  32'(tx_oper_s[d]), 32'(oper));
        check({name, ".grant"}, 32'(grant_s[d]),   32'(4'b0001 << sel));
        repeat (hold - 1) tick();
        tx_done_s[d] = 1'b1;
        tick();
        tx_done_s[d] = 1'b0;
        check({name, ".stop"}, 32'(tx_start_s[d]), 32'd0);
    endtask

    task automatic check_all_zero(input int d, input string name);
        check({name, ".tx_start"}, 32'(tx_start_s[d]),    32'd0);
        check({name, ".grant"},    32'(grant_s[d]),       32'd0);
        check({name, ".pending"},  32'(req_pending_s[d]), 32'd0);
        check({name, ".sel"},      32'(tx_sel_s[d]),      32'd0);
        check({name, ".oper"},     32'(tx_oper_s[d]),     32'd0);
        check({name, ".drop"},     32'(req_drop_s[d]),    32'd0);
        check({name, ".timeout"},  32'(timeout_s[d]),     32'd0);
    endtask

    initial begin
        //        start    oper   done  start sel   oper   grant    pend     drop
        tbl[0]  = '{4'b0001, 8'h01, 1'b0, 1'b0, 2'd0, 2'd0, 4'b0000, 4'b0001, 4'b0000};
        tbl[1]  = '{4'b0000, 8'h00, 1'b0, 1'b0, 2'd0, 2'd1, 4'b0000, 4'b0000, 4'b0000};
        tbl[2]  = '{4'b0100, 8'h20, 1'b0, 1'b1, 2'd0, 2'd1, 4'b0001, 4'b0100, 4'b0000};
        tbl[3]  = '{4'b0100, 8'h30, 1'b0, 1'b1, 2'd0, 2'd1, 4'b0001, 4'b0100, 4'b0100};
        tbl[4]  = '{4'b0000, 8'h00, 1'b0, 1'b1, 2'd0, 2'd1, 4'b0001, 4'b0100, 4'b0000};
        tbl[5]  = '{4'b0000, 8'h00, 1'b1, 1'b0, 2'd0, 2'd1, 4'b0000, 4'b0100, 4'b0000};
        tbl[6]  = '{4'b0000, 8'h00, 1'b0, 1'b0, 2'd2, 2'd2, 4'b0000, 4'b0000, 4'b0000};
        tbl[7]  = '{4'b0000, 8'h00, 1'b0, 1'b1, 2'd2, 2'd2, 4'b0100, 4'b0000, 4'b0000};
        tbl[8]  = '{4'b0100, 8'h10, 1'b0, 1'b1, 2'd2, 2'd2, 4'b0100, 4'b0100, 4'b0000};
        tbl[9]  = '{4'b0000, 8'h00, 1'b1, 1'b0, 2'd2, 2'd2, 4'b0000, 4'b0100, 4'b0000};
        tbl[10] = '{4'b0000, 8'h00, 1'b0, 1'b0, 2'd2, 2'd1, 4'b0000, 4'b0000, 4'b0000};
        tbl[11] = '{4'b0000, 8'h00, 1'b0, 1'b1, 2'd2, 2'd1, 4'b0100, 4'b0000, 4'b0000};
        tbl[12] = '{4'b0000, 8'h00, 1'b1, 1'b0, 2'd2, 2'd1, 4'b0000, 4'b0000, 4'b0000};
        tbl[13] = '{4'b0000, 8'h00, 1'b1, 1'b0, 2'd2, 2'd1, 4'b0000, 4'b0000, 4'b0000};

        for (int d = 0; d < 2; d++) begin
            req_start_s[d] = 4'b0000;
            req_oper_s[d]  = 8'h00;
            tx_done_s[d]   = 1'b0;
        end
        aresetn = 1'b0;
        repeat (3) tick();
        check_all_zero(0, "reset_rr");
        check_all_zero(1, "reset_fp");
        aresetn = 1'b1;
        tick();

        // Drop on double pulse, first oper kept, re-pulse during own WAIT, done ignored when idle.
        for (int r = 0; r < 14; r++) begin
            req_start_s[0] = tbl[r].start;
            req_oper_s[0]  = tbl[r].oper;
            tx_done_s[0]   = tbl[r].done;
            tick();
            check($sformatf("vec%0d.tx_start", r), 32'(tx_start_s[0]),    32'(tbl[r].exp_start));
            check($sformatf("vec%0d.tx_sel", r),   32'(tx_sel_s[0]),      32'(tbl[r].exp_sel));
            check($sformatf("vec%0d.tx_oper", r),  32'(tx_oper_s[0]),     32'(tbl[r].exp_oper));
            check($sformatf("vec%0d.grant", r),    32'(grant_s[0]),       32'(tbl[r].exp_grant));
            check($sformatf("vec%0d.pending", r),  32'(req_pending_s[0]), 32'(tbl[r].exp_pend));
            check($sformatf("vec%0d.drop", r),     32'(req_drop_s[0]),    32'(tbl[r].exp_drop));
        end
        req_start_s[0] = 4'b0000;
        tx_done_s[0]   = 1'b0;

        // Single request latency: start rises two edges after the sampling edge.
        pulse(0, 4'b0010, 8'h08);
        tick();
        check("lat.early", 32'(tx_start_s[0]), 32'd0);
        tick();
        check("lat.start", 32'(tx_start_s[0]), 32'd1);
        check("lat.sel",   32'(tx_sel_s[0]),   32'd1);
        check("lat.oper",  32'(tx_oper_s[0]),  32'd2);
        check("lat.grant", 32'(grant_s[0]),    32'b0010);
        repeat (7) tick();
        check("lat.hold", 32'(tx_start_s[0]), 32'd1);
        tx_done_s[0] = 1'b1;
        tick();
        tx_done_s[0] = 1'b0;
        check("lat.stop",  32'(tx_start_s[0]), 32'd0);
        check("lat.gnt0",  32'(grant_s[0]),    32'd0);
        check("lat.keep",  32'(tx_sel_s[0]),   32'd1);

        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        tick();

        // Round-robin order across two rounds with pointer wrap.
        pulse(0, 4'b1111, 8'hE4);
        for (int k = 0; k < 4; k++) serve(0, 2'(k), 2'(k), 5, $sformatf("rr1_%0d", k));
        pulse(0, 4'b1111, 8'hE4);
        for (int k = 0; k < 4; k++) serve(0, 2'(k), 2'(k), 5, $sformatf("rr2_%0d", k));

        // Watchdog expiry, then next pending served; then done exactly in the expiry cycle.
        pulse(0, 4'b1001, 8'h81);
        wait_start(0, "wd");
        check("wd.sel", 32'(tx_sel_s[0]), 32'd0);
        repeat (15) tick();
        check("wd.pre_start", 32'(tx_start_s[0]), 32'd1);
        check("wd.pre_err",   32'(timeout_s[0]),  32'd0);
        tick();
        check("wd.err",   32'(timeout_s[0]),  32'd1);
        check("wd.stop",  32'(tx_start_s[0]), 32'd0);
        check("wd.gnt0",  32'(grant_s[0]),    32'd0);
        tick();
        check("wd.err_pulse", 32'(timeout_s[0]), 32'd0);
        tick();
        check("wd.next_start", 32'(tx_start_s[0]), 32'd1);
        check("wd.next_sel",   32'(tx_sel_s[0]),   32'd3);
        check("wd.next_oper",  32'(tx_oper_s[0]),  32'd2);
        repeat (15) tick();
        tx_done_s[0] = 1'b1;
        tick();
        tx_done_s[0] = 1'b0;
        check("wd_done.err",  32'(timeout_s[0]),  32'd0);
        check("wd_done.stop", 32'(tx_start_s[0]), 32'd0);
        tick();
        check("wd_done.err2", 32'(timeout_s[0]),  32'd0);

        // Reset in WAIT with two pending requests.
        pulse(0, 4'b0010, 8'h04);
        wait_start(0, "rst");
        pulse(0, 4'b1100, 8'h00);
        check("rst.pend_before", 32'(req_pending_s[0]), 32'b1100);
        aresetn = 1'b0;
        tick();
        check_all_zero(0, "rst_in");
        aresetn = 1'b1;
        repeat (4) tick();
        check("rst.idle_start", 32'(tx_start_s[0]),    32'd0);
        check("rst.idle_pend",  32'(req_pending_s[0]), 32'd0);
        check("rst.idle_gnt",   32'(grant_s[0]),       32'd0);
        pulse(0, 4'b0100, 8'h30);
        serve(0, 2'd2, 2'd3, 3, "rst_new");

        // Fixed priority: ch3+ch1 together, ch0 arrives during ch1 transfer -> 1,0,3.
        pulse(1, 4'b1010, 8'hC4);
        wait_start(1, "fp0");
        check("fp0.sel",  32'(tx_sel_s[1]),  32'd1);
        check("fp0.oper", 32'(tx_oper_s[1]), 32'd1);
        pulse(1, 4'b0001, 8'h02);
        tick();
        tx_done_s[1] = 1'b1;
        tick();
        tx_done_s[1] = 1'b0;
        check("fp0.stop", 32'(tx_start_s[1]), 32'd0);
        serve(1, 2'd0, 2'd2, 3, "fp1");
        serve(1, 2'd3, 2'd3, 3, "fp2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
